uart_io: RTL

//  UART endpoint serving the core-side request/complete byte interface: a one-cycle

---
 rtl/uart_io.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_io.sv
// uart_io: 8N1 UART endpoint with a request/complete byte interface on the core side.
// TX sends one frame per accepted tx_req; RX runs continuously into a one-entry hold
// buffer that is handed to the client when a rx_req has armed a delivery.
module uart_io #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  input  logic       rx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       txd,
  input  logic       rxd
);

  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_BIT / 2 - 1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_LOAD  = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_DATA  = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd4;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  logic [2:0]    tx_state;
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;

  logic [2:0]    rx_state;
  logic [TW-1:0] rx_timer;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;

  logic          buf_full;
  logic [7:0]    buf_data;
  logic          armed;
  logic          byte_good;
  logic          deliver;

  // Transmit FSM: capture the byte one cycle after the request, then shift out the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_req) tx_state <= TX_LOAD;
        end
        TX_LOAD: begin
          tx_shift <= tx_data;
          txd      <= 1'b0;
          tx_timer <= '0;
          tx_state <= TX_START;
        end
        TX_START: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer <= '0;
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer <= '0;
            if (tx_idx == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_idx   <= tx_idx + 3'd1;
            end
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer <= '0;
            tx_done  <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for rxd plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A frame is good when the stop bit samples high at the end of the stop slot.
  assign byte_good = (rx_state == RX_STOP) && (tx_timer == tx_timer) && (rx_timer == BIT_LAST) && rx_sync;
  assign deliver   = armed && buf_full;

  // Receive FSM: mid-bit sampling from the start edge, glitch and framing rejection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state <= RX_IDLE;
      rx_timer <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_timer <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_timer == HALF_LAST) begin
            rx_timer <= '0;
            rx_idx   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_timer == BIT_LAST) begin
            rx_timer <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_timer == BIT_LAST) begin
            rx_timer <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_WAIT;
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Hold buffer and delivery handshake; a byte landing on the emptying edge is kept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_full   <= 1'b0;
      buf_data   <= '0;
      armed      <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_valid <= deliver;
      if (deliver) begin
        rx_data <= buf_data;
        armed   <= 1'b0;
      end else if (rx_req) begin
        armed <= 1'b1;
      end
      if (deliver) begin
        buf_full <= byte_good;
        if (byte_good) buf_data <= rx_shift;
      end else if (byte_good) begin
        if (buf_full) begin
          rx_overrun <= 1'b1;
        end else begin
          buf_full <= 1'b1;
          buf_data <= rx_shift;
        end
      end
    end
  end

endmodule
